// File: rtl/pc_fetch_reg.sv
// Fetch-stage PC register and IF/ID pipeline register with stall, flush, redirect and delay-slot tracking.
// Optional fetch/stall performance counters are enabled by defining FETCH_PERF_EN.
module pc_fetch_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc_in,
  input  logic        is_jump_d,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        valid_d,
  output logic        bd_d,
  output logic        adel_d,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  logic misaligned;
  logic redirect;

  assign misaligned = (pc_f[1:0] != 2'b00);
  assign redirect   = exc_req | eret_req;

  // PC and IF/ID update; exc_req beats eret_req, and any redirect beats stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f    <= RESET_PC;
      instr_d <= 32'h0000_0000;
      pc_d    <= 32'h0000_0000;
      pc4_d   <= 32'h0000_0000;
      valid_d <= 1'b0;
      bd_d    <= 1'b0;
      adel_d  <= 1'b0;
    end else if (redirect) begin
      pc_f    <= exc_req ? EXC_VEC : epc_in;
      instr_d <= 32'h0000_0000;
      valid_d <= 1'b0;
      bd_d    <= 1'b0;
      adel_d  <= 1'b0;
    end else if (stall) begin
      pc_f    <= pc_f;
      instr_d <= instr_d;
      valid_d <= valid_d;
      bd_d    <= bd_d;
      adel_d  <= adel_d;
    end else begin
      pc_f    <= npc_in;
      instr_d <= misaligned ? 32'h0000_0000 : instr_f;
      pc_d    <= pc_f;
      pc4_d   <= pc_f + 32'd4;
      valid_d <= 1'b1;
      bd_d    <= is_jump_d;
      adel_d  <= misaligned;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Performance counters: normal edges and stalled (non-redirected) edges, wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else if (redirect) begin
      fetch_cnt_q <= fetch_cnt_q;
      stall_cnt_q <= stall_cnt_q;
    end else if (stall) begin
      fetch_cnt_q <= fetch_cnt_q;
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign fetch_cnt = 32'h0000_0000;
  assign stall_cnt = 32'h0000_0000;
`endif

endmodule
